cpu1_onchip_mem_arbiter: RTL
============================

# cpu1_onchip_mem_arbiter

Two-requester arbiter that shares the single-port 1024×32 on-chip RAM between the Nios data master (m0) and the alarm event-logger DMA (m1). It presents two independent Avalon-MM slave ports with waitrequest and readdatavalid. It drives one memory command per cycle, chosen round-robin. It tracks each outstanding read through the RAM's fixed read latency so the data returns only to the requester that issued it.

## Interface
Parameters:
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- READ_LATENCY, 1, memory cycles from accepted read to valid mem_readdata (1..4)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes for writes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  high = command not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  command valid
- mem_write  out  1  write strobe
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  RAM clock enable; constant 1
- mem_readdata  in  DATA_W  RAM q, READ_LATENCY after the command

## Operation
- Request: mN_req = mN_read | mN_write.
- If read and write are both high, the command is a write; the read is ignored.
- Grant is combinational from the requests and the priority register prio (1 bit, index of the favoured master).
  - Only one requester active: it is granted.
  - Both active: master prio is granted.
- Acceptance: mN_req & grantN; mN_waitrequest = mN_req & ~grantN.
- A requester that is not requesting sees waitrequest low.
- On acceptance, prio <= ~granted_index. Otherwise prio holds. Result: strict alternation under contention; a lone requester gets every cycle.
- Memory mux: mem_* come from the granted master. mem_chipselect = any grant. mem_write = granted write. mem_byteenable = granted byteenable for writes and 4'hF for reads.
- Response tracking: each accepted read pushes {valid=1, id} into a READ_LATENCY-deep shift register; other cycles push valid=0. At the tail:
  - id 0: m0_readdatavalid = 1
  - id 1: m1_readdatavalid = 1
- mN_readdata = mem_readdata for both ports. Only readdatavalid qualifies it.
- Writes produce no response.
- Requesters hold their command stable while waitrequest is high (Avalon rule). The arbiter neither checks nor latches commands.

## Timing
- Zero-cycle arbitration: a command accepted in cycle N appears on mem_* in cycle N.
- Read data: readdatavalid is asserted in cycle N+READ_LATENCY.
- Throughput: one command per cycle in aggregate; reads may be back-to-back from either or both masters.
- Response order equals issue order; there is no reordering.
- While reset is high:
  - m0_waitrequest = m1_waitrequest = 1
  - mem_chipselect = 0, mem_write = 0
  - readdatavalid = 0 on both ports
  - no acceptance
- After reset: prio = 0; the tag shift register is all-invalid.
- Reset mid-operation: in-flight reads are discarded, and no readdatavalid is emitted for them after reset deasserts.
- Same cycle as a response: a new acceptance is legal and independent of the returning response.

## Structure
- Package cpu1_mem_arb_pkg: ADDR_W, DATA_W, BE_W defaults, typedef master_id_t (1 bit), typedef rsp_tag_t {logic valid; master_id_t id;}.
- Sub-module cpu1_rsp_tag_pipe: parameterised-depth shift register of rsp_tag_t with synchronous clear. Used once.
- Top level holds prio, the grant logic and the muxes.

## Test plan
- Reset: hold reset 3 cycles with m0_read = m1_read = 1 -> both waitrequest = 1, mem_chipselect = 0. After release, m0 is granted first (prio = 0).
- Lone master: m1 writes 0xDEADBEEF at address 0x3FF with byteenable 4'b0011, then reads 0x3FF -> m1_waitrequest low both cycles. Readdatavalid one cycle after the read, data 0x0000BEEF over a zero-initialised word. m0_readdatavalid never asserted.
- Contention: both masters read continuously for 8 cycles, m0 address 0x010 and m1 address 0x020 -> grants alternate m0, m1, m0, ... Each master gets 4 readdatavalid pulses carrying its own address's data, each one cycle after its acceptance.
- Read and write both high: m0_read = m0_write = 1, address 0x005, writedata 0x12345678 -> treated as a write, no readdatavalid. A later read of 0x005 returns 0x12345678.
- Reset mid-flight with READ_LATENCY = 3: m0 read accepted, reset pulsed the next cycle -> no m0_readdatavalid in the following 5 cycles.
- Idle master: m1 idle, m0 issues 10 consecutive reads -> m0_waitrequest low every cycle, 10 responses in order.

Source files
------------

// File: rtl/cpu1_mem_arb_pkg.sv
// Shared definitions for the CPU1 on-chip RAM arbiter.
//   ARB_ADDR_W / ARB_DATA_W / ARB_BE_W : default word-address, data and byteenable widths
//   master_id_t : index of a requesting master (0 = Nios data master, 1 = event-logger DMA)
//   rsp_tag_t   : one slot of the read-response tracker (valid + issuing master)
package cpu1_mem_arb_pkg;

    localparam int ARB_ADDR_W = 10;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = ARB_DATA_W / 8;

    typedef logic master_id_t;

    typedef struct packed {
        logic       valid;
        master_id_t id;
    } rsp_tag_t;

endpackage

// File: rtl/cpu1_rsp_tag_pipe.sv
// Read-response tag delay line. Each cycle one tag enters; it leaves DEPTH cycles
// later, lined up with the RAM's read data for the command that produced it.
//   clk     : clock
//   clear   : synchronous clear, empties every slot (drops in-flight reads)
//   tag_in  : tag for the command issued this cycle (valid=0 when not a read)
//   tag_out : tag whose read data is on the RAM output this cycle
module cpu1_rsp_tag_pipe
    import cpu1_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic     clk,
    input  logic     clear,
    input  rsp_tag_t tag_in,
    output rsp_tag_t tag_out
);

    rsp_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i - 1];
            end
        end
    end

    assign tag_out = stage[DEPTH - 1];

endmodule

// File: rtl/cpu1_onchip_mem_arbiter.sv
// Round-robin arbiter sharing the single-port on-chip RAM between the Nios data
// master (m0) and the alarm event-logger DMA (m1). Arbitration is zero-cycle: the
// granted command drives mem_* in the same cycle it is accepted. Read responses are
// routed back to the issuing master through a tag pipe matching the RAM latency.
//   m0_* / m1_*  : Avalon-MM slave ports (address, byteenable, read, write, writedata,
//                  waitrequest, readdata, readdatavalid)
//   mem_*        : RAM command port (address, byteenable, chipselect, write, writedata,
//                  clken tied high) and read data input mem_readdata
module cpu1_onchip_mem_arbiter
    import cpu1_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int BE_W         = ARB_BE_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    master_id_t prio;
    master_id_t gnt_id;
    logic       req0;
    logic       req1;
    logic       gnt0;
    logic       gnt1;
    logic       accept;
    rsp_tag_t   tag_in;
    rsp_tag_t   tag_out;

    // Grant: a lone requester always wins; under contention the favoured master wins.
    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            gnt0 = req0 & (~req1 | (prio == 1'b0));
            gnt1 = req1 & (~req0 | (prio == 1'b1));
        end
        accept = gnt0 | gnt1;
        gnt_id = gnt1;
    end

    assign m0_waitrequest = reset | (req0 & ~gnt0);
    assign m1_waitrequest = reset | (req1 & ~gnt1);

    // Write wins over read when a master raises both, so only the write strobe is muxed.
    always_comb begin
        mem_chipselect = accept;
        mem_write      = gnt1 ? m1_write : (gnt0 & m0_write);
        mem_address    = gnt1 ? m1_address : m0_address;
        mem_writedata  = gnt1 ? m1_writedata : m0_writedata;
        mem_byteenable = '1;
        if (mem_write) begin
            mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
        end
    end

    assign mem_clken = 1'b1;

    // After every acceptance the other master becomes favoured.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= ~gnt_id;
        end
    end

    always_comb begin
        tag_in.valid = accept & ~mem_write;
        tag_in.id    = gnt_id;
    end

    cpu1_rsp_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .clear   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // The tail slot is only cleared at the reset edge, so gate with reset directly.
    assign m0_readdatavalid = ~reset & tag_out.valid & (tag_out.id == 1'b0);
    assign m1_readdatavalid = ~reset & tag_out.valid & (tag_out.id == 1'b1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule
